// File: rtl/dsp_issue_seq.sv
// Decode/issue sequencer feeding the ALU stage and writing its result back to an 8x32 register file.
// Optional retired-instruction counter enabled by defining DSP_RETIRE_CNT_EN.
module dsp_issue_seq #(
    parameter int NREGS = 8,
    parameter int IMM_W = 16
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        ins_valid,
    output logic        ins_ready,
    input  logic [31:0] ins_word,
    output logic [2:0]  func,
    output logic [31:0] data_as,
    output logic [31:0] data_bs,
    output logic [31:0] ins_delay,
    output logic [31:0] IF_pcss,
    input  logic [31:0] alu_result,
    input  logic        arith_flag,
    input  logic [2:0]  dbg_addr,
    output logic [31:0] dbg_data,
    output logic        illegal_op,
    output logic [15:0] retire_cnt
);

    localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1;

    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_LDI = 3'b011;

    // Encoding doubles as the ins_delay phase value.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        EXEC  = 2'd2,
        WB    = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [2:0]     func_q, func_d;
    logic [31:0]    a_q, a_d, b_q, b_d;
    logic [31:0]    pc_q, pc_d;
    logic [AW-1:0]  rd_q, rd_d;
    logic           ill_q, ill_d;
    logic [31:0]    rf_q [NREGS];
    logic [31:0]    rf_d [NREGS];

    logic [2:0]     op;
    logic [AW-1:0]  rd_f, rs1_f, rs2_f;
    logic [31:0]    imm_ext;
    logic           accept;

    assign op      = ins_word[31:29];
    assign rd_f    = ins_word[26 +: AW];
    assign rs1_f   = ins_word[23 +: AW];
    assign rs2_f   = ins_word[20 +: AW];
    assign imm_ext = {{(32-IMM_W){1'b0}}, ins_word[IMM_W-1:0]};
    assign accept  = ins_valid && (state_q == IDLE);

    always_comb begin
        state_d = state_q;
        func_d  = func_q;
        a_d     = a_q;
        b_d     = b_q;
        pc_d    = pc_q;
        rd_d    = rd_q;
        ill_d   = ill_q;
        rf_d    = rf_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    // Instruction count skips 0 on wrap so the ALU is never re-idled.
                    pc_d = (pc_q == 32'hFFFF_FFFF) ? 32'd1 : pc_q + 32'd1;
                    case (op)
                        OP_ADD, OP_MUL: begin
                            state_d = ISSUE;
                            func_d  = op;
                            a_d     = rf_q[rs1_f];
                            b_d     = rf_q[rs2_f];
                            rd_d    = rd_f;
                        end
                        OP_LDI:  rf_d[rd_f] = imm_ext;
                        OP_NOP:  ;
                        default: ill_d = 1'b1;
                    endcase
                end
            end
            ISSUE: state_d = EXEC;
            EXEC:  state_d = WB;
            WB: begin
                state_d = IDLE;
                if (arith_flag) rf_d[rd_q] = alu_result;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= IDLE;
            func_q  <= '0;
            a_q     <= '0;
            b_q     <= '0;
            pc_q    <= '0;
            rd_q    <= '0;
            ill_q   <= 1'b0;
            rf_q    <= '{default: '0};
        end else begin
            state_q <= state_d;
            func_q  <= func_d;
            a_q     <= a_d;
            b_q     <= b_d;
            pc_q    <= pc_d;
            rd_q    <= rd_d;
            ill_q   <= ill_d;
            rf_q    <= rf_d;
        end
    end

`ifdef DSP_RETIRE_CNT_EN
    logic [15:0] ret_q, ret_d;

    always_comb begin
        ret_d = ret_q;
        if ((state_q == WB && arith_flag) || (accept && op == OP_LDI))
            ret_d = ret_q + 16'd1;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) ret_q <= '0;
        else       ret_q <= ret_d;
    end

    assign retire_cnt = ret_q;
`else
    assign retire_cnt = '0;
`endif

    assign ins_ready  = (state_q == IDLE);
    assign ins_delay  = {30'd0, state_q};
    assign func       = func_q;
    assign data_as    = a_q;
    assign data_bs    = b_q;
    assign IF_pcss    = pc_q;
    assign illegal_op = ill_q;
    assign dbg_data   = rf_q[dbg_addr[AW-1:0]];

    // Reserved instruction bits and any address bits above the file depth.
    logic unused_bits;
    assign unused_bits = ^{ins_word, dbg_addr};

endmodule

// File: tb/tb_dsp_issue_seq.sv
// Scoreboarded bench for dsp_issue_seq with a small behavioural ALU attached.
module tb_dsp_issue_seq;

    logic        clk, nrst, ins_valid, ins_ready, arith_flag, illegal_op;
    logic [31:0] ins_word, data_as, data_bs, ins_delay, IF_pcss, alu_result, dbg_data;
    logic [2:0]  func, dbg_addr;
    logic [15:0] retire_cnt;

    int total = 0;
    int passed = 0;

`ifdef DSP_RETIRE_CNT_EN
    localparam bit RET_EN = 1'b1;
`else
    localparam bit RET_EN = 1'b0;
`endif

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
    } exp_t;
    exp_t sbq[$];

    dsp_issue_seq dut (
        .clk(clk), .nrst(nrst), .ins_valid(ins_valid), .ins_ready(ins_ready),
        .ins_word(ins_word), .func(func), .data_as(data_as), .data_bs(data_bs),
        .ins_delay(ins_delay), .IF_pcss(IF_pcss), .alu_result(alu_result),
        .arith_flag(arith_flag), .dbg_addr(dbg_addr), .dbg_data(dbg_data),
        .illegal_op(illegal_op), .retire_cnt(retire_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External ALU: computes on the edge leaving EXEC, flags done during WB.
    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            arith_flag <= 1'b0;
            alu_result <= '0;
        end else begin
            arith_flag <= (ins_delay == 32'd2) && (IF_pcss != 0);
            if (ins_delay == 32'd2 && IF_pcss != 0)
                alu_result <= (func == 3'b001) ? data_as + data_bs : data_as * data_bs;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
        else passed++;
    endtask

    function automatic logic [31:0] mk(input logic [2:0] op, input logic [2:0] rd,
                                       input logic [2:0] rs1, input logic [2:0] rs2,
                                       input logic [15:0] imm);
        return {op, rd, rs1, rs2, 4'b0, imm};
    endfunction

    // Monitor: every WB phase must match the oldest issued arithmetic op.
    always @(negedge clk) begin
        if (nrst && ins_delay == 32'd3) begin
            if (sbq.size() == 0) begin
                total++;
                $display("FAIL sb_unexpected_wb: got WB with func %h expected none", func);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("sb_func", {29'd0, func}, {29'd0, e.f});
                chk("sb_data_as", data_as, e.a);
                chk("sb_data_bs", data_bs, e.b);
            end
        end
    end

    task automatic issue(input logic [31:0] w);
        int n;
        n = 0;
        while (!ins_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!ins_ready) chk("ready_timeout", {31'd0, ins_ready}, 32'd1);
        ins_valid = 1'b1;
        ins_word  = w;
        @(negedge clk);
        ins_valid = 1'b0;
        ins_word  = '0;
    endtask

    task automatic run_arith(input logic [31:0] w, input logic [2:0] f, input logic [31:0] a,
                             input logic [31:0] b, input logic [2:0] rd, input logic [31:0] res);
        sbq.push_back('{f: f, a: a, b: b});
        issue(w);
        for (int ph = 1; ph <= 3; ph++) begin
            chk("phase_delay", ins_delay, ph);
            chk("phase_ready", {31'd0, ins_ready}, 32'd0);
            chk("phase_func", {29'd0, func}, {29'd0, f});
            @(negedge clk);
        end
        chk("post_delay", ins_delay, 32'd0);
        chk("post_ready", {31'd0, ins_ready}, 32'd1);
        dbg_addr = rd;
        #1 chk("wb_value", dbg_data, res);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int acc, last;
        nrst = 1'b0; ins_valid = 1'b0; ins_word = '0; dbg_addr = '0;
        repeat (2) @(negedge clk);
        chk("rst_ready", {31'd0, ins_ready}, 32'd1);
        chk("rst_delay", ins_delay, 32'd0);
        chk("rst_pcss", IF_pcss, 32'd0);
        chk("rst_data_as", data_as, 32'd0);
        chk("rst_func", {29'd0, func}, 32'd0);
        chk("rst_illegal", {31'd0, illegal_op}, 32'd0);
        chk("rst_retire", {16'd0, retire_cnt}, 32'd0);
        nrst = 1'b1;
        @(negedge clk);

        issue(mk(3'b011, 3'd1, 3'd0, 3'd0, 16'd5));
        issue(mk(3'b011, 3'd2, 3'd0, 3'd0, 16'd7));
        chk("ldi_pcss", IF_pcss, 32'd2);
        dbg_addr = 3'd1;
        #1 chk("ldi_r1", dbg_data, 32'd5);

        run_arith(mk(3'b001, 3'd3, 3'd1, 3'd2, 16'd0), 3'b001, 32'd5, 32'd7, 3'd3, 32'd12);
        chk("add_pcss", IF_pcss, 32'd3);
        chk("retire_3", {16'd0, retire_cnt}, RET_EN ? 32'd3 : 32'd0);

        run_arith(mk(3'b010, 3'd4, 3'd3, 3'd1, 16'd0), 3'b010, 32'd12, 32'd5, 3'd4, 32'd60);

        issue(mk(3'b011, 3'd1, 3'd0, 3'd0, 16'hFFFF));
        run_arith(mk(3'b010, 3'd2, 3'd1, 3'd1, 16'd0), 3'b010, 32'h0000FFFF, 32'h0000FFFF,
                  3'd2, 32'hFFFE0001);
        run_arith(mk(3'b010, 3'd3, 3'd2, 3'd2, 16'd0), 3'b010, 32'hFFFE0001, 32'hFFFE0001,
                  3'd3, 32'hFFFC0001);
        chk("mul_pcss", IF_pcss, 32'd7);
        chk("retire_7", {16'd0, retire_cnt}, RET_EN ? 32'd7 : 32'd0);

        // Continuous ADD stream: accepts must land every 4th cycle.
        ins_word  = mk(3'b001, 3'd6, 3'd1, 3'd1, 16'd0);
        ins_valid = 1'b1;
        acc = 0;
        last = -1;
        for (int i = 0; i < 16; i++) begin
            if (ins_ready) begin
                sbq.push_back('{f: 3'b001, a: 32'h0000FFFF, b: 32'h0000FFFF});
                if (last >= 0) chk("stream_gap", i - last, 32'd4);
                last = i;
                acc++;
            end
            @(negedge clk);
        end
        ins_valid = 1'b0;
        chk("stream_accepts", acc, 32'd4);
        chk("stream_pcss", IF_pcss, 32'd11);
        dbg_addr = 3'd6;
        #1 chk("stream_r6", dbg_data, 32'h0001FFFE);

        // Reset during EXEC: nothing written back.
        @(negedge clk);
        issue(mk(3'b001, 3'd5, 3'd1, 3'd1, 16'd0));
        @(negedge clk);
        chk("pre_rst_exec", ins_delay, 32'd2);
        nrst = 1'b0;
        #1;
        chk("arst_delay", ins_delay, 32'd0);
        chk("arst_func", {29'd0, func}, 32'd0);
        chk("arst_data_as", data_as, 32'd0);
        chk("arst_data_bs", data_bs, 32'd0);
        chk("arst_pcss", IF_pcss, 32'd0);
        chk("arst_ready", {31'd0, ins_ready}, 32'd1);
        @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
        dbg_addr = 3'd5;
        #1 chk("arst_r5", dbg_data, 32'd0);
        dbg_addr = 3'd1;
        #1 chk("arst_r1", dbg_data, 32'd0);
        chk("arst_ready_rel", {31'd0, ins_ready}, 32'd1);

        // Illegal opcode acts as NOP but latches the flag.
        @(negedge clk);
        issue(mk(3'b011, 3'd2, 3'd0, 3'd0, 16'd9));
        issue(mk(3'b101, 3'd2, 3'd0, 3'd0, 16'h0055));
        chk("ill_set", {31'd0, illegal_op}, 32'd1);
        chk("ill_ready", {31'd0, ins_ready}, 32'd1);
        chk("ill_pcss", IF_pcss, 32'd2);
        issue(mk(3'b000, 3'd0, 3'd0, 3'd0, 16'd0));
        chk("ill_sticky", {31'd0, illegal_op}, 32'd1);
        chk("nop_pcss", IF_pcss, 32'd3);
        dbg_addr = 3'd2;
        #1 chk("ill_r2", dbg_data, 32'd9);
        chk("retire_ill", {16'd0, retire_cnt}, RET_EN ? 32'd1 : 32'd0);

        repeat (3) @(negedge clk);
        chk("sb_drained", sbq.size(), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/dsp_issue_seq.md
Name: dsp_issue_seq

Overview:
- Instruction decode/issue sequencer directly upstream of the ALU stage; also consumes the ALU's result for writeback.
- Accepts 32-bit instruction words over a valid/ready handshake and decodes them.
- Reads operands from an internal 8x32 register file and drives func/data_as/data_bs/ins_delay/IF_pcss so the ALU fires exactly once per arithmetic instruction.
- Writes the ALU result back to the register file.

Parameters:
- NREGS, 8, register-file depth; must be a power of 2, max 8 (3-bit register fields).
- IMM_W, 16, immediate width for LDI; zero-extended to 32.

Ports:
- clk  in  1  system clock, all state on posedge.
- nrst  in  1  asynchronous active-low reset.
- ins_valid  in  1  instruction word present.
- ins_ready  out  1  sequencer can accept an instruction this cycle.
- ins_word  in  32  [31:29] op, [28:26] rd, [25:23] rs1, [22:20] rs2, [15:0] imm.
- func  out  3  ALU function (001 add, 010 mul).
- data_as  out  32  operand A (rf[rs1]).
- data_bs  out  32  operand B (rf[rs2]).
- ins_delay  out  32  issue phase counter, values 0..3.
- IF_pcss  out  32  count of accepted instructions; 0 holds the ALU idle.
- alu_result  in  32  ALU result.
- arith_flag  in  1  ALU arithmetic-done flag.
- dbg_addr  in  3  register-file debug read address.
- dbg_data  out  32  rf[dbg_addr], combinational.
- illegal_op  out  1  sticky; set on opcode 100-111.
- retire_cnt  out  16  retired-instruction counter (see Optional Feature).

Behaviour:
- Reset (async, nrst=0): state IDLE. Outputs func=0, data_as=0, data_bs=0, ins_delay=0, IF_pcss=0, illegal_op=0, retire_cnt=0. All registers zero. Reset mid-operation aborts the instruction with no writeback.
- Handshake: ins_ready = (state==IDLE). Accept occurs on the posedge where ins_valid && ins_ready. ins_word is don't-care otherwise.
- On every accept: IF_pcss increments by 1, wrapping 0xFFFFFFFF to 1, never 0.
- Opcodes:
  - 000 NOP: accept only; stay IDLE.
  - 011 LDI: rf[rd] <= {16'b0, imm} on the accept edge; stay IDLE. Single cycle.
  - 001 ADD, 010 MUL: on accept, latch func=op, data_as=rf[rs1], data_bs=rf[rs2], rd; go to ISSUE.
  - 100-111: treated as NOP; set illegal_op (stays set until reset).
- FSM (ins_delay value in parentheses):
  - IDLE(0) -> ISSUE(1) on accept of ADD/MUL.
  - ISSUE(1) -> EXEC(2) unconditionally.
  - EXEC(2) -> WB(3) unconditionally. The ALU computes on the edge leaving EXEC.
  - WB(3) -> IDLE(0). On the edge leaving WB, if arith_flag==1 then rf[rd] <= alu_result.
- ins_delay holds 2 for exactly one cycle per ADD/MUL. func/data_as/data_bs are stable from ISSUE through WB and hold their values in IDLE.
- Throughput:
  - ADD/MUL: 4 cycles from accept to the next possible accept.
  - LDI/NOP: 1 cycle, back-to-back.
- Hazards: none. Issue is blocked until WB completes, so the next instruction reads the updated register.
- Arithmetic: no sign handling. Results are the ALU's 32-bit truncation; this block stores them unmodified.
- rd=rs1=rs2 is legal; operands are read before writeback.

Optional Feature:
- Macro: DSP_RETIRE_CNT_EN.
- Defined: retire_cnt increments by 1 when an ADD/MUL leaves WB with a writeback, and when an LDI is accepted. It wraps 0xFFFF->0 and resets to 0.
- Undefined: retire_cnt tied to 0; no counter logic.

Test Plan:
- LDI r1=5, LDI r2=7, ADD r3,r1,r2 -> ins_delay sequence 0,1,2,3,0; dbg r3=12; IF_pcss=3; ins_ready low for 3 cycles.
- Then MUL r4,r3,r1 -> dbg r4=60 after WB; func=010 during ISSUE..WB.
- LDI r1=0xFFFF, MUL r2,r1,r1, MUL r3,r2,r2 -> r2=0xFFFE0001, r3=0xFFFC0001 (32-bit wrap).
- ins_valid held high with a stream of ADDs -> accepts exactly every 4th cycle; no accept while ins_ready=0.
- Drop nrst during EXEC of ADD r5 -> all outputs 0 asynchronously; r5=0; IF_pcss=0; after release ins_ready=1.
- Opcode 101 accepted -> illegal_op=1 and stays 1; registers unchanged. With DSP_RETIRE_CNT_EN, retire_cnt counts only LDI/ADD/MUL (e.g. 3 after LDI, LDI, ADD).
